myproject_sdiv_32s_19s_19_seq: RTL and testbench
================================================

// Module: myproject_sdiv_32s_19s_19_seq
// PURPOSE
//  Sequential signed divider, inverse of the 19s x 19s -> 32 multiplier in the layernorm datapath.
//  Divides a 32-bit signed product/accumulator by a 19-bit signed divisor, giving a 19-bit signed quotient.
//  Restoring radix-2, one quotient bit per clock; valid/ready in and out; used for mean/variance normalisation.
// PARAMETERS
//  din0_WIDTH  32  dividend width (signed)
//  din1_WIDTH  19  divisor width (signed)
//  dout_WIDTH  19  quotient width (signed, saturated)
// PORTS
//  ap_clk     in   1           clock; all logic on rising edge
//  ap_rst_n   in   1           reset, synchronous, active-low
//  din_vld    in   1           operands valid
//  din_rdy    out  1           block can accept operands (high only in IDLE)
//  din0       in   din0_WIDTH  dividend
//  din1       in   din1_WIDTH  divisor
//  dout_vld   out  1           result valid; held until dout_rdy
//  dout_rdy   in   1           downstream accepts result
//  dout       out  dout_WIDTH  quotient, truncated toward zero, saturated
//  dout_sat   out  1           dout saturated (overflow or divide-by-zero)
//  dout_dbz   out  1           divisor was zero
//  dout_rem   out  din1_WIDTH  remainder, sign of dividend (only with MYPROJECT_SDIV_REM_EN)
// BEHAVIOUR
//  Reset (ap_rst_n=0 at edge): state IDLE; din_rdy=0 that cycle, 1 after; dout_vld=0; dout, dout_sat, dout_dbz, dout_rem=0.
//  Reset mid-operation aborts the divide; no result issued; operands discarded.
//  FSM: IDLE -(din_vld&din_rdy)-> CALC -(count==din0_WIDTH-1)-> FIX -> DONE -(dout_rdy)-> IDLE.
//  IDLE: latch |din0|, |din1|, sign bits, dbz=(din1==0); counter=0.
//  CALC: shift partial remainder left, trial-subtract |divisor|, set quotient bit; din0_WIDTH cycles.
//  FIX: apply sign (quot negative iff signs differ; rem takes dividend sign); saturate to
//    [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1]; set dout_sat if clipped; register outputs.
//  dbz: quotient forced to max (+ve or zero dividend) or min (-ve dividend); dout_sat=1, dout_dbz=1, rem=0;
//    still takes full latency (constant timing).
//  Latency: handshake in cycle 0 -> dout_vld=1 in cycle din0_WIDTH+2 (34 by default). Throughput 1 per 35 cycles min.
//  DONE: dout/flags stable while dout_vld & !dout_rdy. din_rdy=0 outside IDLE; same-cycle dout accept + new input
//    not supported (new input accepted the cycle after return to IDLE).
//  Magnitudes use din0_WIDTH+1 bit unsigned so -2^31 is exact; internal remainder din1_WIDTH+1 bits.
//  X on din0/din1 when din_vld=0 must not propagate to any output.
// CONFIGURATION
//  MYPROJECT_SDIV_REM_EN defined: dout_rem port present, driven per FIX rules.
//  Undefined: dout_rem port absent; remainder sign-fix logic removed; quotient/timing identical.
// STRUCTURE
//  Package myproject_sdiv_pkg: state enum (IDLE, CALC, FIX, DONE), counter width $clog2(din0_WIDTH),
//    function sat_signed(value, width) shared with other saturating layernorm blocks.
//  Sub-module: myproject_sdiv_step (one combinational restoring step: shift, trial subtract, qbit);
//    top holds FSM, counter, registers, sign/saturation fix.
// TESTING
//  1000 / 7 -> dout=142, rem=6, sat=0, dbz=0, dout_vld exactly 34 cycles after handshake.
//  -1000 / 7 -> dout=-142, rem=-6; 1000 / -7 -> dout=-142, rem=6; -1000 / -7 -> 142, rem=-6.
//  5 / 0 -> dout=262143, sat=1, dbz=1; -5 / 0 -> dout=-262144, sat=1, dbz=1; 0 / 0 -> 262143.
//  -2^31 / 1 -> dout=-262144, sat=1, dbz=0; 2^31-1 / -1 -> dout=-262144, sat=1; 262143 / 1 -> 262143, sat=0.
//  dout_rdy held low 10 cycles after result -> dout stable, din_rdy=0 throughout; release -> IDLE next cycle.
//  ap_rst_n low at CALC cycle 15 -> no dout_vld; next op 100 / 3 -> 33, rem 1, correct latency.

Source files
------------

// File: rtl/myproject_sdiv_pkg.sv
// myproject_sdiv_pkg: shared widths, FSM states and the signed saturation helper for the sequential divider
package myproject_sdiv_pkg;
    localparam int DIN0_WIDTH = 32;
    localparam int DIN1_WIDTH = 19;
    localparam int DOUT_WIDTH = 19;
    localparam int CNT_WIDTH  = $clog2(DIN0_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    // Clip a signed value into [-2^(width-1), 2^(width-1)-1]
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        return (value > hi) ? hi : (value < lo) ? lo : value;
    endfunction
endpackage

// File: rtl/myproject_sdiv_step.sv
// myproject_sdiv_step: one combinational restoring-division step
//   rem      partial remainder in
//   dvd_bit  next dividend bit shifted in
//   dsr      divisor magnitude
//   rem_next partial remainder out
//   qbit     quotient bit produced by this step
module myproject_sdiv_step
    import myproject_sdiv_pkg::*;
(
    input  logic [DIN1_WIDTH:0]   rem,
    input  logic                  dvd_bit,
    input  logic [DIN1_WIDTH-1:0] dsr,
    output logic [DIN1_WIDTH:0]   rem_next,
    output logic                  qbit
);
    localparam int RW = DIN1_WIDTH + 1;

    logic [RW:0] shifted;
    logic [RW:0] diff;

    assign shifted  = {rem, dvd_bit};
    assign diff     = shifted - {2'b0, dsr};
    // Trial subtraction succeeded when the difference did not go negative
    assign qbit     = !diff[RW];
    assign rem_next = RW'(qbit ? diff : shifted);
endmodule

// File: rtl/myproject_sdiv_32s_19s_19_seq.sv
// myproject_sdiv_32s_19s_19_seq: sequential signed 32s / 19s divider with saturated 19-bit quotient
//   ap_clk, ap_rst_n   clock, synchronous active-low reset
//   din_vld/din_rdy    operand handshake (ready only in IDLE)
//   din0, din1         signed dividend, signed divisor
//   dout_vld/dout_rdy  result handshake, result held until accepted
//   dout               quotient truncated toward zero, saturated
//   dout_sat, dout_dbz saturation and divide-by-zero flags
//   dout_rem           remainder with dividend sign, present only with MYPROJECT_SDIV_REM_EN
module myproject_sdiv_32s_19s_19_seq
    import myproject_sdiv_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  din_vld,
    output logic                  din_rdy,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  dout_vld,
    input  logic                  dout_rdy,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  dout_sat,
    output logic                  dout_dbz
`ifdef MYPROJECT_SDIV_REM_EN
    ,
    output logic [DIN1_WIDTH-1:0] dout_rem
`endif
);
    state_t                state, state_next;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DIN0_WIDTH-1:0] dvd, quo;
    logic [DIN1_WIDTH-1:0] dsr;
    logic [DIN1_WIDTH:0]   rem, rem_next;
    logic                  qbit, neg_q, neg_r, dbz;
    logic signed [63:0]    q_ext, q_sat;

    myproject_sdiv_step u_step (
        .rem      (rem),
        .dvd_bit  (dvd[DIN0_WIDTH-1]),
        .dsr      (dsr),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    assign din_rdy = ap_rst_n && state == IDLE;

    always_comb begin
        state_next = state;
        state_next = (state == IDLE && din_vld) ? CALC :
                     (state == CALC && cnt == CNT_WIDTH'(DIN0_WIDTH - 1)) ? FIX :
                     (state == FIX) ? DONE :
                     (state == DONE && dout_rdy) ? IDLE : state;
    end

    // Divide-by-zero feeds an out-of-range extreme through the same clip so dout_sat falls out naturally
    assign q_ext = dbz ? (neg_r ? 64'sh8000_0000_0000_0000 : 64'sh7fff_ffff_ffff_ffff) :
                   neg_q ? -$signed(64'(quo)) : $signed(64'(quo));
    assign q_sat = sat_signed(q_ext, DOUT_WIDTH);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            quo      <= '0;
            dsr      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz      <= 1'b0;
            dout_vld <= 1'b0;
            dout     <= '0;
            dout_sat <= 1'b0;
            dout_dbz <= 1'b0;
`ifdef MYPROJECT_SDIV_REM_EN
            dout_rem <= '0;
`endif
        end else begin
            state <= state_next;
            if (state == IDLE && din_vld) begin
                // Unsigned magnitudes: -2^31 maps exactly onto 2^31
                dvd   <= din0[DIN0_WIDTH-1] ? -din0 : din0;
                dsr   <= din1[DIN1_WIDTH-1] ? -din1 : din1;
                neg_r <= din0[DIN0_WIDTH-1];
                neg_q <= din0[DIN0_WIDTH-1] ^ din1[DIN1_WIDTH-1];
                dbz   <= din1 == '0;
                cnt   <= '0;
                rem   <= '0;
                quo   <= '0;
            end
            if (state == CALC) begin
                dvd <= dvd << 1;
                rem <= rem_next;
                quo <= {quo[DIN0_WIDTH-2:0], qbit};
                cnt <= cnt + CNT_WIDTH'(1);
            end
            if (state == FIX) begin
                dout_vld <= 1'b1;
                dout     <= DOUT_WIDTH'(q_sat);
                dout_sat <= q_sat != q_ext;
                dout_dbz <= dbz;
`ifdef MYPROJECT_SDIV_REM_EN
                dout_rem <= dbz ? '0 : neg_r ? -DIN1_WIDTH'(rem) : DIN1_WIDTH'(rem);
`endif
            end
            if (state == DONE && dout_rdy)
                dout_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_myproject_sdiv_32s_19s_19_seq.sv
// tb_myproject_sdiv_32s_19s_19_seq: scoreboard bench for the sequential signed divider
module tb_myproject_sdiv_32s_19s_19_seq;
`ifdef MYPROJECT_SDIV_REM_EN
    localparam bit REM_ON = 1'b1;
`else
    localparam bit REM_ON = 1'b0;
`endif

    typedef struct packed {
        logic [18:0] q;
        logic        sat;
        logic        dbz;
        logic [18:0] rem;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        din_vld = 1'b0;
    logic        dout_rdy = 1'b0;
    logic [31:0] din0 = '0;
    logic [18:0] din1 = '0;
    logic        din_rdy, dout_vld, dout_sat, dout_dbz;
    logic [18:0] dout;
    logic [18:0] rem_obs;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

`ifdef MYPROJECT_SDIV_REM_EN
    logic [18:0] dout_rem;
    assign rem_obs = dout_rem;
`else
    assign rem_obs = '0;
`endif

    myproject_sdiv_32s_19s_19_seq dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .din0     (din0),
        .din1     (din1),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .dout     (dout),
        .dout_sat (dout_sat),
        .dout_dbz (dout_dbz)
`ifdef MYPROJECT_SDIV_REM_EN
        ,
        .dout_rem (dout_rem)
`endif
    );

    function automatic exp_t mk(input int q, input bit sat, input bit dbz, input int rem);
        exp_t e;
        e.q = 19'(q);
        e.sat = sat;
        e.dbz = dbz;
        e.rem = REM_ON ? 19'(rem) : 19'd0;
        return e;
    endfunction

    function automatic exp_t model(input logic signed [31:0] a, input logic signed [18:0] b);
        longint q, r;
        if (b == 0) return mk(a < 0 ? -262144 : 262143, 1'b1, 1'b1, 0);
        q = longint'(a) / longint'(b);
        r = longint'(a) % longint'(b);
        if (q > 262143) return mk(262143, 1'b1, 1'b0, int'(r));
        if (q < -262144) return mk(-262144, 1'b1, 1'b0, int'(r));
        return mk(int'(q), 1'b0, 1'b0, int'(r));
    endfunction

    task automatic send(input logic [31:0] a, input logic [18:0] b, input exp_t e, input bit push, output int c0);
        int n = 0;
        @(negedge ap_clk);
        while (!din_rdy && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        checks++;
        if (din_rdy !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: din_rdy=%0b required 1 within 100 cycles", din_rdy);
        end
        din_vld = 1'b1;
        din0 = a;
        din1 = b;
        c0 = cyc;
        if (push) sb.push_back(e);
        @(posedge ap_clk);
        #1;
        din_vld = 1'b0;
        din0 = 'x;
        din1 = 'x;
    endtask

    task automatic wait_vld(output int t, output bit got);
        int n = 0;
        @(negedge ap_clk);
        while (!dout_vld && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        got = dout_vld;
        t = cyc;
    endtask

    task automatic accept;
        dout_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        dout_rdy = 1'b0;
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if ({din_rdy, dout_vld, dout, dout_sat, dout_dbz, rem_obs} !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b vld=%0b dout=%0d sat=%0b dbz=%0b rem=%0d required all 0",
                     din_rdy, dout_vld, dout, dout_sat, dout_dbz, rem_obs);
        end
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if (din_rdy !== 1'b1 || dout_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%0b vld=%0b required rdy=1 vld=0", din_rdy, dout_vld);
        end
    endtask

    task automatic test_divide;
        int va[12], vb[12], vq[12], vs[12], vd[12], vr[12];
        int c0, t;
        bit got;
        exp_t e;
        va = '{1000, -1000, 1000, -1000, 262143, 5, -5, 0,
               int'(32'h8000_0000), 2147483647, int'(32'h8000_0000), 262144};
        vb = '{7, 7, -7, -7, 1, 0, 0, 0, 1, -1, -1, 1};
        vq = '{142, -142, -142, 142, 262143, 262143, -262144, 262143, -262144, -262144, 262143, 262143};
        vs = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        vd = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        vr = '{6, -6, 6, -6, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            send(32'(va[i]), 19'(vb[i]), mk(vq[i], vs[i][0], vd[i][0], vr[i]), 1'b1, c0);
            wait_vld(t, got);
            e = sb.pop_front();
            checks++;
            if (!got || {dout, dout_sat, dout_dbz, rem_obs} !== e) begin
                errors++;
                $display("FAIL divide_%0d: vld=%0b dout=%0d sat=%0b dbz=%0b rem=%0d required dout=%0d sat=%0b dbz=%0b rem=%0d",
                         i, got, $signed(dout), dout_sat, dout_dbz, $signed(rem_obs),
                         $signed(e.q), e.sat, e.dbz, $signed(e.rem));
            end
            checks++;
            if (t - c0 != 34) begin
                errors++;
                $display("FAIL divide_%0d_latency: %0d cycles required 34", i, t - c0);
            end
            accept;
        end
    endtask

    task automatic test_backpressure;
        int c0, t;
        bit got;
        exp_t e;
        send(32'd1000, 19'd7, mk(142, 1'b0, 1'b0, 6), 1'b1, c0);
        wait_vld(t, got);
        e = sb.pop_front();
        checks++;
        if (!got || {dout, dout_sat, dout_dbz, rem_obs} !== e) begin
            errors++;
            $display("FAIL backpressure_result: vld=%0b dout=%0d required %0d", got, $signed(dout), $signed(e.q));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            checks++;
            if (dout_vld !== 1'b1 || din_rdy !== 1'b0 || dout !== e.q) begin
                errors++;
                $display("FAIL backpressure_hold_%0d: vld=%0b rdy=%0b dout=%0d required vld=1 rdy=0 dout=%0d",
                         i, dout_vld, din_rdy, $signed(dout), $signed(e.q));
            end
        end
        accept;
        @(negedge ap_clk);
        checks++;
        if (dout_vld !== 1'b0 || din_rdy !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: vld=%0b rdy=%0b required vld=0 rdy=1", dout_vld, din_rdy);
        end
    endtask

    task automatic test_reset_abort;
        int c0, t, seen;
        bit got;
        exp_t e;
        send(32'd100, 19'd7, mk(14, 1'b0, 1'b0, 2), 1'b0, c0);
        repeat (14) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge ap_clk);
            if (dout_vld) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_result: dout_vld high for %0d cycles required 0", seen);
        end
        send(32'd100, 19'd3, mk(33, 1'b0, 1'b0, 1), 1'b1, c0);
        wait_vld(t, got);
        e = sb.pop_front();
        checks++;
        if (!got || {dout, dout_sat, dout_dbz, rem_obs} !== e) begin
            errors++;
            $display("FAIL abort_next_op: vld=%0b dout=%0d rem=%0d required dout=%0d rem=%0d",
                     got, $signed(dout), $signed(rem_obs), $signed(e.q), $signed(e.rem));
        end
        checks++;
        if (t - c0 != 34) begin
            errors++;
            $display("FAIL abort_next_latency: %0d cycles required 34", t - c0);
        end
        accept;
    endtask

    task automatic test_back_to_back;
        int c0, t;
        bit got;
        logic [31:0] a;
        logic [18:0] b;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = 19'($urandom);
            if (i % 2 == 1) a = 32'($signed(a) >>> 9);
            if (i % 3 == 0) b = 19'($urandom_range(1, 60));
            if (i == 4) b = 19'h7ffc1;
            if (i == 7) b = '0;
            send(a, b, model($signed(a), $signed(b)), 1'b1, c0);
            wait_vld(t, got);
            e = sb.pop_front();
            checks++;
            if (!got || {dout, dout_sat, dout_dbz, rem_obs} !== e) begin
                errors++;
                $display("FAIL b2b_%0d: a=%0d b=%0d vld=%0b dout=%0d sat=%0b dbz=%0b rem=%0d required dout=%0d sat=%0b dbz=%0b rem=%0d",
                         i, $signed(a), $signed(b), got, $signed(dout), dout_sat, dout_dbz, $signed(rem_obs),
                         $signed(e.q), e.sat, e.dbz, $signed(e.rem));
            end
            checks++;
            if (t - c0 != 34) begin
                errors++;
                $display("FAIL b2b_%0d_latency: %0d cycles required 34", i, t - c0);
            end
            accept;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_divide();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
